// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline control slice.
//   - opcode constants for the instruction subset
//   - forwarding-select encodings for EX operand muxes
//   - hazard controller state encoding
//   - scoreboard entry and decoded-dependency structs
//   - fwd_select(): youngest-producer-wins forwarding choice
package mips32_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BEQZ  = 6'b001101;
   localparam logic [5:0] OP_BNEQZ = 6'b001110;
   localparam logic [5:0] OP_J     = 6'b010000;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EXM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StLdStall = 2'b01,
      StDrain   = 2'b10,
      StHalt    = 2'b11
   } hz_state_e;

   // dest == 0 means the entry writes nothing.
   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
      logic       is_hlt;
   } sb_entry_t;

   // Source enables are already cleared for register 0.
   typedef struct packed {
      logic       src1_en;
      logic [4:0] src1;
      logic       src2_en;
      logic [4:0] src2;
      logic       dst_en;
      logic [4:0] dst;
      logic       is_load;
      logic       is_hlt;
   } deps_t;

   // EX/MEM producer is younger than MEM/WB, so it is checked first.
   function automatic logic [1:0] fwd_select(input logic en, input logic [4:0] src,
                                             input sb_entry_t ex, input sb_entry_t mem);
      if (en && ex.valid && (ex.dest == src)) begin
         return FWD_EXM;
      end else if (en && mem.valid && (mem.dest == src)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/mips32_hazard_ctrl_if.sv
// Bundle between the mips32 datapath and its hazard controller.
//   datapath -> ctrl : id_valid, id_ir, br_taken
//   ctrl -> datapath : pc_we, if_id_we, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
//                      halted, stall_cnt, flush_cnt
// master = datapath side, slave = controller side.
interface mips32_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [31:0]      id_ir;
   logic             br_taken;
   logic             pc_we;
   logic             if_id_we;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_ir, br_taken,
      input  pc_we, if_id_we, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_ir, br_taken,
      output pc_we, if_id_we, if_id_flush, id_ex_bubble, fwd_a, fwd_b,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/mips32_idecode_deps.sv
// Combinational register-dependency decode of the instruction held in IF/ID.
//   valid_i : IF/ID holds a real instruction (0 decodes as NOP)
//   ir_i    : IF_ID_IR
//   deps_o  : sources, destination, load and halt flags
module mips32_idecode_deps #(
   parameter logic [5:0] OP_HLT = 6'b111111
) (
   input  logic              valid_i,
   input  logic [31:0]       ir_i,
   output mips32_pkg::deps_t deps_o
);
   import mips32_pkg::*;

   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   logic       unused_ir;

   assign op        = ir_i[31:26];
   assign rs        = ir_i[25:21];
   assign rt        = ir_i[20:16];
   assign rd        = ir_i[15:11];
   assign unused_ir = ^ir_i[10:0];

   always_comb begin
      deps_o = '0;
      if (valid_i) begin
         if (op == OP_HLT) begin
            deps_o.is_hlt = 1'b1;
         end else if (op <= OP_SLT) begin
            deps_o.src1_en = (rs != 5'd0);
            deps_o.src1    = rs;
            deps_o.src2_en = (rt != 5'd0);
            deps_o.src2    = rt;
            deps_o.dst_en  = (rd != 5'd0);
            deps_o.dst     = rd;
         end else if ((op >= OP_ADDI) && (op <= OP_SLTI)) begin
            deps_o.src1_en = (rs != 5'd0);
            deps_o.src1    = rs;
            deps_o.dst_en  = (rt != 5'd0);
            deps_o.dst     = rt;
         end else if (op == OP_LW) begin
            deps_o.src1_en = (rs != 5'd0);
            deps_o.src1    = rs;
            deps_o.dst_en  = (rt != 5'd0);
            deps_o.dst     = rt;
            deps_o.is_load = 1'b1;
         end else if (op == OP_SW) begin
            deps_o.src1_en = (rs != 5'd0);
            deps_o.src1    = rs;
            deps_o.src2_en = (rt != 5'd0);
            deps_o.src2    = rt;
         end else if ((op == OP_BEQZ) || (op == OP_BNEQZ)) begin
            deps_o.src1_en = (rs != 5'd0);
            deps_o.src1    = rs;
         end
         // OP_J and unknown opcodes carry no dependencies.
      end
   end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage mips32 datapath.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of mips32_hazard_ctrl_if (ID instruction and branch
//                resolution in; PC/IF/ID enables, flush/bubble, registered EX
//                forwarding selects, halt flag and perf counters out)
// A 3-entry scoreboard mirrors ID/EX, EX/MEM and MEM/WB destinations.
module mips32_hazard_ctrl #(
   parameter int unsigned CNT_W  = 16,
   parameter logic [5:0]  OP_HLT = 6'b111111
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips32_hazard_ctrl_if.slave  bus
);
   import mips32_pkg::*;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   hz_state_e  state_q, state_d;
   sb_entry_t  sb_ex_q, sb_mem_q, sb_wb_q, sb_id;
   deps_t      deps;
   logic [1:0] fwd_a_q, fwd_b_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
   logic       ld_use, br_flush, stall;
   logic       pc_we, if_id_we, if_id_flush, id_ex_bubble;
   logic       unused_sb;

   mips32_idecode_deps #(
      .OP_HLT (OP_HLT)
   ) u_idecode (
      .valid_i (bus.id_valid),
      .ir_i    (bus.id_ir),
      .deps_o  (deps)
   );

   // Load in ID/EX whose result is needed by the instruction in ID.
   assign ld_use = sb_ex_q.valid && sb_ex_q.is_load &&
                   ((deps.src1_en && (deps.src1 == sb_ex_q.dest)) ||
                    (deps.src2_en && (deps.src2 == sb_ex_q.dest)));

   // A halted pipeline ignores branch resolution.
   assign br_flush = bus.br_taken && (state_q != StHalt);

   assign sb_id.valid   = bus.id_valid;
   assign sb_id.dest    = deps.dst_en ? deps.dst : 5'd0;
   assign sb_id.is_load = deps.is_load;
   assign sb_id.is_hlt  = deps.is_hlt;

   always_comb begin
      state_d      = state_q;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall        = 1'b0;
      unique case (state_q)
         StRun: begin
            if (ld_use) begin
               pc_we        = 1'b0;
               if_id_we     = 1'b0;
               id_ex_bubble = 1'b1;
               stall        = 1'b1;
               state_d      = StLdStall;
            end else if (deps.is_hlt) begin
               state_d = StDrain;
            end
         end
         StLdStall: begin
            state_d = StRun;
         end
         StDrain: begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
            if (sb_wb_q.is_hlt) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
         end
         default: begin
            state_d = StRun;
         end
      endcase
      // Taken branch wins over stall/drain: kill the two wrong-path instructions.
      if (br_flush) begin
         pc_we        = 1'b1;
         if_id_we     = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         stall        = 1'b0;
         state_d      = StRun;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         sb_ex_q     <= '0;
         sb_mem_q    <= '0;
         sb_wb_q     <= '0;
         fwd_a_q     <= FWD_RF;
         fwd_b_q     <= FWD_RF;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sb_ex_q  <= id_ex_bubble ? '0 : sb_id;
         sb_mem_q <= br_flush ? '0 : sb_ex_q;
         sb_wb_q  <= sb_mem_q;
         fwd_a_q  <= id_ex_bubble ? FWD_RF
                                  : fwd_select(deps.src1_en, deps.src1, sb_ex_q, sb_mem_q);
         fwd_b_q  <= id_ex_bubble ? FWD_RF
                                  : fwd_select(deps.src2_en, deps.src2, sb_ex_q, sb_mem_q);
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CntOne;
         end
         if (br_flush && !(&flush_cnt_q)) begin
            flush_cnt_q <= flush_cnt_q + CntOne;
         end
      end
   end

   assign unused_sb = ^{sb_wb_q.valid, sb_wb_q.dest, sb_wb_q.is_load};

   assign bus.pc_we        = pc_we;
   assign bus.if_id_we     = if_id_we;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.fwd_a        = fwd_a_q;
   assign bus.fwd_b        = fwd_b_q;
   assign bus.halted       = (state_q == StHalt);
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Directed bench for mips32_hazard_ctrl. A second instance with 4-bit counters
// exercises counter saturation in a short run.
module tb_mips32_hazard_ctrl;
   import mips32_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mips32_hazard_ctrl_if #(.CNT_W(16)) bus ();
   mips32_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

   mips32_hazard_ctrl #(.CNT_W(16), .OP_HLT(OP_HLT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mips32_hazard_ctrl #(.CNT_W(4), .OP_HLT(OP_HLT)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'd0};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
      return {op, rs, rt, 16'd0};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [31:0] ir, input logic br);
      bus.id_valid = valid;
      bus.id_ir    = ir;
      bus.br_taken = br;
      #1;
   endtask

   initial begin
      bus.id_valid  = 1'b0;
      bus.id_ir     = 32'h0;
      bus.br_taken  = 1'b0;
      bus4.id_valid = 1'b0;
      bus4.id_ir    = 32'h0;
      bus4.br_taken = 1'b0;

      // Reset values
      #2;
      check_eq("rst_pc_we", bus.pc_we, 1);
      check_eq("rst_if_id_we", bus.if_id_we, 1);
      check_eq("rst_flush", bus.if_id_flush, 0);
      check_eq("rst_bubble", bus.id_ex_bubble, 0);
      check_eq("rst_halted", bus.halted, 0);
      check_eq("rst_fwd_a", bus.fwd_a, FWD_RF);
      check_eq("rst_fwd_b", bus.fwd_b, FWD_RF);
      check_eq("rst_stall_cnt", bus.stall_cnt, 0);
      check_eq("rst_flush_cnt", bus.flush_cnt, 0);
      #10 rst_n = 1'b1;
      next_cycle();
      next_cycle();

      // Saturation on the 4-bit instance: LW r2,0(r2) held in ID stalls every
      // other cycle, 25 stalls > 2^4+3.
      bus4.id_valid = 1'b1;
      bus4.id_ir    = itype(OP_LW, 5'd2, 5'd2);
      repeat (50) next_cycle();
      check_eq("sat_stall_cnt", bus4.stall_cnt, 4'hF);
      bus4.id_valid = 1'b0;
      bus4.br_taken = 1'b1;
      repeat (20) next_cycle();
      bus4.br_taken = 1'b0;
      check_eq("sat_flush_cnt", bus4.flush_cnt, 4'hF);
      check_eq("sat_stall_hold", bus4.stall_cnt, 4'hF);

      // Load-use stall then forward from MEM/WB
      drive(1'b1, itype(OP_LW, 5'd1, 5'd2), 1'b0);
      check_eq("lw_no_stall", bus.pc_we, 1);
      next_cycle();
      drive(1'b1, rtype(OP_ADD, 5'd2, 5'd4, 5'd3), 1'b0);
      check_eq("lu_pc_we", bus.pc_we, 0);
      check_eq("lu_if_id_we", bus.if_id_we, 0);
      check_eq("lu_bubble", bus.id_ex_bubble, 1);
      check_eq("lu_flush", bus.if_id_flush, 0);
      next_cycle();
      check_eq("ldst_pc_we", bus.pc_we, 1);
      check_eq("ldst_bubble", bus.id_ex_bubble, 0);
      check_eq("ldst_stall_cnt", bus.stall_cnt, 1);
      check_eq("ldst_fwd_a_bubble", bus.fwd_a, FWD_RF);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      check_eq("lu_fwd_a", bus.fwd_a, FWD_WB);
      check_eq("lu_fwd_b", bus.fwd_b, FWD_RF);
      check_eq("lu_stall_once", bus.stall_cnt, 1);
      check_eq("lu_resume", bus.pc_we, 1);
      repeat (3) next_cycle();

      // Back-to-back ALU forwarding
      drive(1'b1, rtype(OP_ADD, 5'd1, 5'd1, 5'd5), 1'b0);
      next_cycle();
      drive(1'b1, rtype(OP_SUB, 5'd5, 5'd5, 5'd6), 1'b0);
      check_eq("alu_sub_no_stall", bus.pc_we, 1);
      check_eq("alu_sub_no_bubble", bus.id_ex_bubble, 0);
      next_cycle();
      drive(1'b1, rtype(OP_AND, 5'd5, 5'd6, 5'd7), 1'b0);
      check_eq("sub_fwd_a", bus.fwd_a, FWD_EXM);
      check_eq("sub_fwd_b", bus.fwd_b, FWD_EXM);
      check_eq("alu_and_no_stall", bus.pc_we, 1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      check_eq("and_fwd_a", bus.fwd_a, FWD_WB);
      check_eq("and_fwd_b", bus.fwd_b, FWD_EXM);
      repeat (3) next_cycle();

      // Register 0 is never a dependency
      drive(1'b1, rtype(OP_ADD, 5'd1, 5'd1, 5'd0), 1'b0);
      next_cycle();
      drive(1'b1, rtype(OP_ADD, 5'd0, 5'd0, 5'd3), 1'b0);
      check_eq("r0_no_stall", bus.pc_we, 1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      check_eq("r0_fwd_a", bus.fwd_a, FWD_RF);
      check_eq("r0_fwd_b", bus.fwd_b, FWD_RF);
      repeat (3) next_cycle();

      // Invalid ID slot with a matching rs
      drive(1'b1, itype(OP_LW, 5'd1, 5'd2), 1'b0);
      next_cycle();
      drive(1'b0, rtype(OP_ADD, 5'd2, 5'd4, 5'd3), 1'b0);
      check_eq("inv_pc_we", bus.pc_we, 1);
      check_eq("inv_bubble", bus.id_ex_bubble, 0);
      next_cycle();
      check_eq("inv_fwd_a", bus.fwd_a, FWD_RF);

      // Taken branch coincident with a load-use hazard
      drive(1'b1, itype(OP_LW, 5'd1, 5'd2), 1'b0);
      next_cycle();
      drive(1'b1, rtype(OP_ADD, 5'd2, 5'd4, 5'd3), 1'b1);
      check_eq("br_flush", bus.if_id_flush, 1);
      check_eq("br_bubble", bus.id_ex_bubble, 1);
      check_eq("br_pc_we", bus.pc_we, 1);
      next_cycle();

      // HLT in ID right after the branch; state must be RUN to accept it
      drive(1'b1, {OP_HLT, 26'd0}, 1'b0);
      check_eq("br_flush_cnt", bus.flush_cnt, 1);
      check_eq("br_stall_cnt", bus.stall_cnt, 1);
      check_eq("hlt_id_pc_we", bus.pc_we, 1);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0);
      check_eq("drain_pc_we", bus.pc_we, 0);
      check_eq("drain_flush", bus.if_id_flush, 1);
      check_eq("drain_halted", bus.halted, 0);
      next_cycle();
      next_cycle();
      check_eq("drain3_halted", bus.halted, 0);
      check_eq("drain3_pc_we", bus.pc_we, 0);
      next_cycle();
      check_eq("halt_halted", bus.halted, 1);
      check_eq("halt_pc_we", bus.pc_we, 0);
      check_eq("halt_if_id_we", bus.if_id_we, 0);
      check_eq("halt_bubble", bus.id_ex_bubble, 1);
      for (int i = 0; i < 20; i++) begin
         next_cycle();
         check_eq("halt_hold_halted", bus.halted, 1);
         check_eq("halt_hold_pc_we", bus.pc_we, 0);
      end

      // Asynchronous reset mid-cycle
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_halted", bus.halted, 0);
      check_eq("arst_pc_we", bus.pc_we, 1);
      check_eq("arst_if_id_we", bus.if_id_we, 1);
      check_eq("arst_flush", bus.if_id_flush, 0);
      check_eq("arst_bubble", bus.id_ex_bubble, 0);
      check_eq("arst_stall_cnt", bus.stall_cnt, 0);
      check_eq("arst_flush_cnt", bus.flush_cnt, 0);
      check_eq("arst_fwd_a", bus.fwd_a, FWD_RF);
      check_eq("arst_sat_cnt", bus4.stall_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
